// File: rtl/mem_port_scheduler_pkg.sv
// mem_port_scheduler_pkg: shared state/requester encodings and grant priority for the memory port scheduler
package mem_port_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {REQ_IC, REQ_DCR, REQ_DCW} req_id_t;
  localparam int STARVE_LIMIT_DEF = 4;
  function automatic req_id_t pick(input logic dcr, input logic dcw, input logic force_ic);
    return force_ic ? REQ_IC : dcw ? REQ_DCW : dcr ? REQ_DCR : REQ_IC;
  endfunction
endpackage

// File: rtl/mem_port_scheduler_if.sv
// mem_port_scheduler_if: pipeline request/ack signals and IOCTRL port signals of the memory port scheduler
interface mem_port_scheduler_if;
  logic ic_read_req;
  logic [31:0] ic_read_addr;
  logic ic_read_ack;
  logic [31:0] ic_read_data;
  logic dc_read_req;
  logic [31:0] dc_read_addr;
  logic dc_read_ack;
  logic [31:0] dc_read_data;
  logic dc_write_req;
  logic [31:0] dc_write_addr;
  logic [31:0] dc_write_data;
  logic dc_write_ack;
  logic mem_read;
  logic mem_write;
  logic mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_write;
  logic [31:0] mem_data_read;
  logic bus_error;
  modport slave (
    input ic_read_req, ic_read_addr, dc_read_req, dc_read_addr, dc_write_req, dc_write_addr, dc_write_data,
          mem_ack, mem_data_read,
    output ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack, mem_read, mem_write,
           mem_addr, mem_data_write, bus_error
  );
  modport master (
    output ic_read_req, ic_read_addr, dc_read_req, dc_read_addr, dc_write_req, dc_write_addr, dc_write_data,
           mem_ack, mem_data_read,
    input ic_read_ack, ic_read_data, dc_read_ack, dc_read_data, dc_write_ack, mem_read, mem_write,
          mem_addr, mem_data_write, bus_error
  );
endinterface

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: serialises fetch/load/store onto one IOCTRL port with priority, anti-starvation and watchdog
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic clk,
  input logic reset,
  mem_port_scheduler_if.slave bus
);
  state_t state, state_n;
  req_id_t win, win_n, pick_id;
  logic rd, rd_n, wr, wr_n, berr, berr_n;
  logic [2:0] acks, acks_n;
  logic [31:0] addr, addr_n, wdata, wdata_n, ic_data, ic_data_n, dc_data, dc_data_n;
  logic [3:0] starve, starve_n;
  logic [15:0] wd, wd_n;
  always_comb begin
    pick_id = pick(bus.dc_read_req, bus.dc_write_req, bus.ic_read_req && starve >= 4'(STARVE_LIMIT));
    state_n = state;
    win_n = win;
    rd_n = rd;
    wr_n = wr;
    addr_n = addr;
    wdata_n = wdata;
    ic_data_n = ic_data;
    dc_data_n = dc_data;
    acks_n = '0;
    berr_n = 1'b0;
    starve_n = bus.ic_read_req ? starve : '0;
    wd_n = wd;
    if (state == IDLE && (bus.ic_read_req || bus.dc_read_req || bus.dc_write_req)) begin
      state_n = BUSY;
      win_n = pick_id;
      rd_n = pick_id != REQ_DCW;
      wr_n = pick_id == REQ_DCW;
      addr_n = pick_id == REQ_DCW ? bus.dc_write_addr : pick_id == REQ_DCR ? bus.dc_read_addr : bus.ic_read_addr;
      wdata_n = pick_id == REQ_DCW ? bus.dc_write_data : wdata;
      starve_n = (pick_id == REQ_IC || !bus.ic_read_req) ? '0 : starve + 4'(starve != 4'hf);
      wd_n = '0;
    end else if (state == BUSY && bus.mem_ack) begin
      state_n = RESP;
      rd_n = 1'b0;
      wr_n = 1'b0;
      ic_data_n = win == REQ_IC ? bus.mem_data_read : ic_data;
      dc_data_n = win == REQ_DCR ? bus.mem_data_read : dc_data;
      acks_n = 3'b001 << win;
    end else if (state == BUSY && TIMEOUT_CYCLES > 0 && wd + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
      state_n = IDLE;
      rd_n = 1'b0;
      wr_n = 1'b0;
      berr_n = 1'b1;
    end else if (state == BUSY) begin
      wd_n = wd + 16'd1;
    end else if (state == RESP) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      win <= REQ_IC;
      rd <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      ic_data <= '0;
      dc_data <= '0;
      acks <= '0;
      berr <= 1'b0;
      starve <= '0;
      wd <= '0;
    end else begin
      state <= state_n;
      win <= win_n;
      rd <= rd_n;
      wr <= wr_n;
      addr <= addr_n;
      wdata <= wdata_n;
      ic_data <= ic_data_n;
      dc_data <= dc_data_n;
      acks <= acks_n;
      berr <= berr_n;
      starve <= starve_n;
      wd <= wd_n;
    end
  end
  assign bus.ic_read_ack = acks[0];
  assign bus.dc_read_ack = acks[1];
  assign bus.dc_write_ack = acks[2];
  assign bus.ic_read_data = ic_data;
  assign bus.dc_read_data = dc_data;
  assign bus.mem_read = rd;
  assign bus.mem_write = wr;
  assign bus.mem_addr = addr;
  assign bus.mem_data_write = wdata;
  assign bus.bus_error = berr;
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed and random requests against a transaction-level model of the port scheduler
module tb_mem_port_scheduler;
  import mem_port_scheduler_pkg::*;
  localparam int LIMIT = 4;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_port_scheduler_if bus();
  mem_port_scheduler #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic pend[3];
  logic [31:0] paddr[3];
  logic [31:0] pwdata, exp_data, fix_data, m_ic, m_dc;
  logic [2:0] exp_ackv;
  logic exp_berr, busy, mute, stray, sticky, fix_en;
  int starve, age, dly, cur, fixed_dly, berr_cnt, t0, b0;
  int last_ack[3];
  int glog[$];
  int exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr(input int r);
    return {4'(r + 1), 28'($urandom)};
  endfunction

  function automatic int model_pick();
    if (pend[0] && starve >= LIMIT) return 0;
    if (pend[2]) return 2;
    if (pend[1]) return 1;
    return 0;
  endfunction

  task automatic drive();
    bus.ic_read_req = pend[0];
    bus.ic_read_addr = paddr[0];
    bus.dc_read_req = pend[1];
    bus.dc_read_addr = paddr[1];
    bus.dc_write_req = pend[2];
    bus.dc_write_addr = paddr[2];
    bus.dc_write_data = pwdata;
  endtask

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] d);
    pend[r] = 1'b1;
    paddr[r] = a;
    if (r == 2) pwdata = d;
    drive();
  endtask

  task automatic tick();
    logic [2:0] ackv;
    logic strobe, ack_now;
    @(posedge clk);
    #1;
    cyc++;
    ackv = {bus.dc_write_ack, bus.dc_read_ack, bus.ic_read_ack};
    strobe = bus.mem_read | bus.mem_write;
    if (reset) begin
      exp_ackv = '0;
      exp_berr = 1'b0;
      m_ic = '0;
      m_dc = '0;
      starve = 0;
      busy = 1'b0;
      chk("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_data_write, 0);
    end else begin
      if (exp_ackv[0]) m_ic = exp_data;
      if (exp_ackv[1]) m_dc = exp_data;
    end
    chk("ack_vec", 32'(ackv), 32'(exp_ackv));
    chk("bus_error", 32'(bus.bus_error), 32'(exp_berr));
    chk("ic_read_data", bus.ic_read_data, m_ic);
    chk("dc_read_data", bus.dc_read_data, m_dc);
    if (bus.bus_error) berr_cnt++;
    exp_ackv = '0;
    exp_berr = 1'b0;
    ack_now = 1'b0;
    if (!reset) begin
      if (!pend[0]) starve = 0;
      if (strobe && !busy) begin
        cur = model_pick();
        starve = (cur == 0 || !pend[0]) ? 0 : (starve < 15 ? starve + 1 : 15);
        busy = 1'b1;
        age = 0;
        dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 4));
        glog.push_back(bus.mem_write ? 2 : (bus.mem_addr[31:28] == 4'h1 ? 0 : 1));
        chk("grant_kind", 32'({bus.mem_write, bus.mem_read}), cur == 2 ? 32'd2 : 32'd1);
        chk("grant_addr", bus.mem_addr, paddr[cur]);
        if (cur == 2) chk("grant_wdata", bus.mem_data_write, pwdata);
      end else if (strobe) begin
        age++;
        chk("addr_hold", bus.mem_addr, paddr[cur]);
      end else begin
        busy = 1'b0;
      end
      if (strobe && mute && age == TMO - 1) exp_berr = 1'b1;
      if (strobe && !mute && age >= dly) begin
        ack_now = 1'b1;
        exp_data = fix_en ? fix_data : $urandom;
        exp_ackv = 3'(1 << cur);
      end
    end
    bus.mem_ack = ack_now | stray;
    bus.mem_data_read = ack_now ? exp_data : $urandom;
    for (int r = 0; r < 3; r++)
      if (ackv[r]) begin
        last_ack[r] = cyc;
        if (sticky) begin
          paddr[r] = rnd_addr(r);
          if (r == 2) pwdata = $urandom;
        end else pend[r] = 1'b0;
      end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend[0] || pend[1] || pend[2] || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 1);
  endtask

  initial begin
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0;
      paddr[r] = '0;
      last_ack[r] = 0;
    end
    pwdata = '0; exp_data = '0; fix_data = '0; m_ic = '0; m_dc = '0; exp_ackv = '0;
    exp_berr = 1'b0; busy = 1'b0; mute = 1'b0; stray = 1'b0; sticky = 1'b0; fix_en = 1'b0;
    starve = 0; age = 0; dly = 0; cur = 0; fixed_dly = -1; berr_cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_data_read = '0;
    drive();
    repeat (2) tick();
    reset = 1'b0;
    tick();
    // lone fetch with mem_ack two cycles after the strobe
    fixed_dly = 2; fix_en = 1'b1; fix_data = 32'hDEADBEEF;
    t0 = cyc;
    issue(0, 32'h100, 0);
    drain(20);
    chk("ic_latency", last_ack[0] - t0, 4);
    chk("ic_data_final", bus.ic_read_data, 32'hDEADBEEF);
    fix_en = 1'b0; fixed_dly = -1;
    issue(2, 32'h200, 32'h12345678);
    drain(20);
    // dc_read beats ic; ic follows three cycles later
    fixed_dly = 0;
    issue(0, rnd_addr(0), 0);
    issue(1, rnd_addr(1), 0);
    drain(20);
    chk("contention_gap", last_ack[0] - last_ack[1], 3);
    issue(1, rnd_addr(1), 0);
    issue(2, rnd_addr(2), $urandom);
    drain(20);
    chk("write_before_read", last_ack[1] - last_ack[2], 3);
    // both ic and dc_read held continuously
    sticky = 1'b1;
    glog.delete();
    issue(0, rnd_addr(0), 0);
    issue(1, rnd_addr(1), 0);
    t0 = 0;
    while (glog.size() < 10 && t0 < 200) begin
      tick();
      t0++;
    end
    for (int i = 0; i < 10; i++) chk("starve_order", i < glog.size() ? glog[i] : -1, exp_order[i]);
    sticky = 1'b0;
    drain(40);
    // watchdog: no mem_ack for two full timeouts, then normal completion
    fixed_dly = -1; mute = 1'b1;
    b0 = berr_cnt;
    issue(1, rnd_addr(1), 0);
    repeat (19) tick();
    chk("wd_pulses", berr_cnt - b0, 2);
    mute = 1'b0;
    drain(20);
    // reset mid-transaction, then stray mem_ack while idle
    mute = 1'b1;
    issue(0, rnd_addr(0), 0);
    repeat (3) tick();
    chk("busy_before_reset", 32'(bus.mem_read), 1);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) pend[r] = 1'b0;
    drive();
    tick();
    reset = 1'b0;
    mute = 1'b0;
    stray = 1'b1;
    repeat (3) tick();
    stray = 1'b0;
    repeat (2) tick();
    issue(0, rnd_addr(0), 0);
    drain(20);
    // random mix including simultaneous dc read/write
    for (int k = 0; k < 300; k++) begin
      tick();
      for (int r = 0; r < 3; r++)
        if (!pend[r] && $urandom_range(0, 3) == 0) issue(r, rnd_addr(r), $urandom);
    end
    drain(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
